// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch counter with lap freeze and MM:SS radix.
// Feeds the seven-segment display with a registered packed digit bus.
module stopwatch_core #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_COUNT = 2000,
    parameter int MMSS_MODE       = 1,
    parameter int WRAP            = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic                    btn_start,
    input  logic                    btn_lap,
    output logic [4*NUM_DIGITS-1:0] digit_data,
    output logic                    running,
    output logic                    lap_active,
    output logic                    overflow
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int PW = (TICKS_PER_COUNT > 1) ? $clog2(TICKS_PER_COUNT) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] lap_q, lap_d;
    logic [DW-1:0] disp_q, disp_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ovf_q, ovf_d;
    logic          start_prev_q, start_prev_d;
    logic          lap_prev_q, lap_prev_d;

    logic [DW-1:0] inc_val;
    logic          carry;
    logic [3:0]    dig;
    logic [3:0]    dmax;
    logic          at_max;
    logic          start_press;
    logic          lap_press;
    logic          active;
    logic          step;

    assign start_press = btn_start & ~start_prev_q;
    assign lap_press   = btn_lap & ~lap_prev_q;
    assign active      = (state_q == RUN) || (state_q == LAP);
    assign step        = active & tick_in & (presc_q == PMAX);

    // Ripple BCD increment of the live count; carry-out flags the maximum value
    always_comb begin
        inc_val = count_q;
        carry   = 1'b1;
        dig     = 4'd0;
        dmax    = 4'd9;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig  = count_q[4*i +: 4];
            dmax = (MMSS_MODE != 0 && (i == 1 || i == 3)) ? 4'd5 : 4'd9;
            if (carry) begin
                if (dig == dmax) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        at_max = carry;
    end

    // Next-state, prescaler, count, lap capture and display selection
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        presc_d      = presc_q;
        ovf_d        = ovf_q;
        start_prev_d = btn_start;
        lap_prev_d   = btn_lap;
        disp_d       = (state_q == LAP) ? lap_q : count_q;

        if (active && tick_in) begin
            presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        end

        if (step) begin
            if (at_max) begin
                ovf_d = 1'b1;
            end
            if (!at_max || WRAP != 0) begin
                count_d = inc_val;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start_press) state_d = RUN;
            end
            RUN: begin
                if (start_press) begin
                    state_d = PAUSE;
                end else if (lap_press) begin
                    state_d = LAP;
                    lap_d   = count_q;
                end
            end
            LAP: begin
                if (start_press)    state_d = PAUSE;
                else if (lap_press) state_d = RUN;
            end
            PAUSE: begin
                if (start_press)    state_d = RUN;
                else if (lap_press) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Saturating overflow stops the watch regardless of any press
        if (step && at_max && WRAP == 0) begin
            state_d = PAUSE;
        end

        if (state_d == IDLE) begin
            count_d = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            lap_q        <= '0;
            disp_q       <= '0;
            presc_q      <= '0;
            ovf_q        <= 1'b0;
            start_prev_q <= 1'b1;
            lap_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
            presc_q      <= presc_d;
            ovf_q        <= ovf_d;
            start_prev_q <= start_prev_d;
            lap_prev_q   <= lap_prev_d;
        end
    end

    assign digit_data = disp_q;
    assign running    = (state_q == RUN) || (state_q == LAP);
    assign lap_active = (state_q == LAP);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: scoreboard bench for two stopwatch_core configurations.
// A: 4 digits, MM:SS, wrap, 2 ticks/count. B: 2 digits, decimal, saturate, 1 tick/count.
module tb_stopwatch_core;

  logic        clk;
  logic        reset_a, tick_a, start_a, lap_a;
  logic        reset_b, tick_b, start_b, lap_b;
  logic [15:0] dd_a;
  logic [7:0]  dd_b;
  logic        run_a, lapact_a, ovf_a;
  logic        run_b, lapact_b, ovf_b;

  int checks;
  int errors;

  typedef struct {
    string       name;
    bit          inst;
    logic [15:0] dd;
    logic        run;
    logic        lap;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  stopwatch_core #(
    .NUM_DIGITS(4), .TICKS_PER_COUNT(2), .MMSS_MODE(1), .WRAP(1)
  ) u_a (
    .clk(clk), .reset(reset_a), .tick_in(tick_a),
    .btn_start(start_a), .btn_lap(lap_a),
    .digit_data(dd_a), .running(run_a),
    .lap_active(lapact_a), .overflow(ovf_a)
  );

  stopwatch_core #(
    .NUM_DIGITS(2), .TICKS_PER_COUNT(1), .MMSS_MODE(0), .WRAP(0)
  ) u_b (
    .clk(clk), .reset(reset_b), .tick_in(tick_b),
    .btn_start(start_b), .btn_lap(lap_b),
    .digit_data(dd_b), .running(run_b),
    .lap_active(lapact_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  exp_t        m_e;
  logic [15:0] m_dd;
  logic        m_run, m_lap, m_ovf;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.inst == 1'b0) begin
        m_dd = dd_a; m_run = run_a;
        m_lap = lapact_a; m_ovf = ovf_a;
      end else begin
        m_dd = {8'h00, dd_b}; m_run = run_b;
        m_lap = lapact_b; m_ovf = ovf_b;
      end
      checks++;
      if (m_dd !== m_e.dd || m_run !== m_e.run ||
          m_lap !== m_e.lap || m_ovf !== m_e.ovf) begin
        errors++;
        $display("FAIL %s: got dd=%h run=%b lap=%b ovf=%b, expected dd=%h run=%b lap=%b ovf=%b",
                 m_e.name, m_dd, m_run, m_lap, m_ovf,
                 m_e.dd, m_e.run, m_e.lap, m_e.ovf);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input bit inst,
                            input logic [15:0] dd,
                            input logic r, input logic l,
                            input logic o);
    exp_t e;
    e.name = name; e.inst = inst; e.dd = dd;
    e.run = r; e.lap = l; e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic press_start_a();
    start_a = 1'b1; cyc(1); start_a = 1'b0; cyc(1);
  endtask

  task automatic press_lap_a();
    lap_a = 1'b1; cyc(1); lap_a = 1'b0; cyc(1);
  endtask

  task automatic ticks_a(input int n);
    tick_a = 1'b1; cyc(n); tick_a = 1'b0; cyc(1);
  endtask

  task automatic press_start_b();
    start_b = 1'b1; cyc(1); start_b = 1'b0; cyc(1);
  endtask

  task automatic press_lap_b();
    lap_b = 1'b1; cyc(1); lap_b = 1'b0; cyc(1);
  endtask

  task automatic ticks_b(input int n);
    tick_b = 1'b1; cyc(n); tick_b = 1'b0; cyc(1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_a = 1'b1; tick_a = 1'b0; start_a = 1'b0; lap_a = 1'b0;
    reset_b = 1'b1; tick_b = 1'b0; start_b = 1'b0; lap_b = 1'b0;
    cyc(2);
    expect_out("a_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    expect_out("b_reset", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_a = 1'b0; reset_b = 1'b0;
    cyc(2);

    press_start_b();
    expect_out("b_start", 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks_b(99);
    expect_out("b_99", 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0);
    ticks_b(1);
    expect_out("b_saturate", 1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
    ticks_b(5);
    expect_out("b_sat_hold", 1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
    press_lap_b();
    expect_out("b_clear", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    press_start_b();
    ticks_b(97);
    expect_out("b_97", 1'b1, 16'h0097, 1'b1, 1'b0, 1'b0);
    press_lap_b();
    expect_out("b_lap", 1'b1, 16'h0097, 1'b1, 1'b1, 1'b0);
    ticks_b(3);
    expect_out("b_sat_from_lap", 1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);

    press_start_a();
    expect_out("a_start", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    ticks_a(20);
    expect_out("a_20ticks", 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0);
    ticks_a(1);
    press_start_a();
    ticks_a(4);
    expect_out("a_pause_hold", 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    press_start_a();
    ticks_a(1);
    expect_out("a_presc_kept", 1'b0, 16'h0011, 1'b1, 1'b0, 1'b0);
    ticks_a(2);
    press_lap_a();
    expect_out("a_lap_freeze", 1'b0, 16'h0012, 1'b1, 1'b1, 1'b0);
    ticks_a(10);
    expect_out("a_lap_frozen", 1'b0, 16'h0012, 1'b1, 1'b1, 1'b0);
    press_lap_a();
    expect_out("a_lap_release", 1'b0, 16'h0017, 1'b1, 1'b0, 1'b0);

    ticks_a(1);
    start_a = 1'b1; lap_a = 1'b1; tick_a = 1'b1;
    cyc(1);
    start_a = 1'b0; lap_a = 1'b0; tick_a = 1'b0;
    cyc(1);
    expect_out("a_simul_pause", 1'b0, 16'h0018, 1'b0, 1'b0, 1'b0);

    press_start_a();
    expect_out("a_resume", 1'b0, 16'h0018, 1'b1, 1'b0, 1'b0);
    ticks_a(82);
    expect_out("a_0059", 1'b0, 16'h0059, 1'b1, 1'b0, 1'b0);
    ticks_a(2);
    expect_out("a_0100", 1'b0, 16'h0100, 1'b1, 1'b0, 1'b0);
    ticks_a(7078);
    expect_out("a_5959", 1'b0, 16'h5959, 1'b1, 1'b0, 1'b0);
    ticks_a(2);
    expect_out("a_wrap", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    ticks_a(2);
    expect_out("a_ovf_sticky", 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
    press_start_a();
    expect_out("a_pause_ovf", 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);
    press_lap_a();
    expect_out("a_clear", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    press_lap_a();
    expect_out("a_idle_lap", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    press_start_a();
    ticks_a(84);
    expect_out("a_0042", 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0);
    reset_a = 1'b1; start_a = 1'b1;
    cyc(1);
    expect_out("a_mid_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_a = 1'b0;
    cyc(3);
    expect_out("a_held_no_press", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    start_a = 1'b0; cyc(1);
    start_a = 1'b1; cyc(1);
    start_a = 1'b0; cyc(1);
    expect_out("a_repress", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    cyc(3);
    @(negedge clk);
    #1;
    checks++;
    if (dd_a !== 16'h0000) begin
      errors++;
      $display("FAIL a_final_dd: got %h", dd_a);
    end
    checks++;
    if (run_a !== 1'b1) begin
      errors++;
      $display("FAIL a_final_run: got %b", run_a);
    end
    checks++;
    if (lapact_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++;
      $display("FAIL a_final_flags: lap=%b ovf=%b", lapact_a, ovf_a);
    end
    checks++;
    if (dd_b !== 8'h99) begin
      errors++;
      $display("FAIL b_final_dd: got %h", dd_b);
    end
    checks++;
    if (run_b !== 1'b0 || lapact_b !== 1'b0) begin
      errors++;
      $display("FAIL b_final_state: run=%b lap=%b", run_b, lapact_b);
    end
    checks++;
    if (ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL b_final_ovf: got %b", ovf_b);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised stopwatch counter that drives the seven-segment display's packed BCD digit bus.
- Sits between the debounced button outputs / divided tick and the display module.
- Counts in NUM_DIGITS BCD digits with optional MM:SS radix.
- Supports start/stop, lap freeze, clear, and wrap or saturate on overflow.

Parameters:
- NUM_DIGITS, 4: number of BCD digits; must be at least 2.
- TICKS_PER_COUNT, 2000: tick_in pulses per count increment; must be at least 1. 2000 at 2 kHz gives 1 s.
- MMSS_MODE, 1: 1 = digits 1 and 3 (if present) roll over at 6, all other digits at 10; 0 = all digits roll over at 10.
- WRAP, 1: 1 = wrap to zero on overflow; 0 = saturate at the maximum value and stop.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset; synchronous, active-high.
- tick_in  input  1  one-cycle count-enable pulse from the clock divider domain logic.
- btn_start  input  1  debounced start/stop level.
- btn_lap  input  1  debounced lap/clear level.
- digit_data  output  4*NUM_DIGITS  packed BCD digits, registered; digit 0 = bits [3:0].
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP (display frozen).
- overflow  output  1  sticky overflow flag.

Behaviour:
- Reset:
  - Synchronous, active-high; dominates all other inputs.
  - Drives state=IDLE, count=0, prescaler=0, lap register=0, digit_data=0, running=0, lap_active=0, overflow=0.
  - Edge-detect history registers reset to 1, so a button held through reset produces no press.
- Press detection:
  - press = input high AND previous-cycle input low.
  - One press per rising edge; a held level does not repeat.
- Prescaler:
  - Width $clog2(TICKS_PER_COUNT), minimum 1 bit.
  - Advances only on tick_in while in RUN or LAP.
  - When prescaler = TICKS_PER_COUNT-1 and tick_in is high: issue a count step and set prescaler to 0.
  - Holds its value in PAUSE; cleared in IDLE.
- FSM states: IDLE, RUN, PAUSE, LAP.
  - IDLE: start -> RUN; lap ignored.
  - RUN: start -> PAUSE; lap -> LAP and capture the current count into the lap register.
  - LAP: start -> PAUSE (display returns to live count); lap -> RUN (release freeze).
  - PAUSE: start -> RUN; lap -> IDLE (count, prescaler and overflow cleared).
  - Start and lap pressed in the same cycle: start wins, lap is discarded.
  - Count step and press in the same cycle: the step is evaluated against the pre-transition state, so a step arriving with a pause press is still applied.
- Count step:
  - BCD ripple increment: digit i increments; on reaching radix-1 it returns to 0 and carries into digit i+1.
  - Digit radix is 10, or 6 for digits 1 and 3 when MMSS_MODE=1.
  - Maximum value: every digit at radix-1 (59:59 for 4 digits with MMSS_MODE=1; 9999 with MMSS_MODE=0).
- Overflow (step taken at the maximum value):
  - WRAP=1: count goes to all zeros, overflow is set, state is unchanged.
  - WRAP=0: count holds at the maximum, overflow is set, state is forced to PAUSE. A LAP state also goes to PAUSE.
  - overflow is sticky; it clears only on reset or on entry to IDLE.
- Output:
  - digit_data is registered: the lap register in LAP, otherwise the live count.
  - Latency: a count step at edge N appears on digit_data at edge N+1.
  - Lap freeze and release take effect on digit_data one cycle after the transition edge.
  - running and lap_active are decoded from the registered state with no extra latency.
- No combinational path from any input to any output.

Test Plan:
- Default mode with TICKS_PER_COUNT=2, MMSS_MODE=0, NUM_DIGITS=4: reset, start press, 20 tick_in pulses -> digit_data=16'h0010, running=1.
- MMSS rollover with MMSS_MODE=1, TICKS_PER_COUNT=1: run 59 ticks -> 16'h0059; next tick -> 16'h0100; continuing to 59:59 plus one tick with WRAP=1 -> 16'h0000, overflow=1, state still RUN.
- Lap, from count 16'h0012 with lap press:
  - 5 more counts -> digit_data stays 16'h0012, lap_active=1, running=1.
  - Second lap press -> digit_data=16'h0017 one cycle later, lap_active=0.
- Saturate with WRAP=0, NUM_DIGITS=2, MMSS_MODE=0: count to 8'h99, one more step -> digit_data=8'h99, overflow=1, running=0 (PAUSE); further ticks produce no change.
- Simultaneous and clear:
  - Start and lap in the same cycle while in RUN -> PAUSE, lap_active=0, count retained.
  - Then a lap press -> IDLE, digit_data=0 one cycle later, overflow=0.
  - Tick coinciding with the pause press -> that step is applied.
- Reset mid-run: at count 16'h0042 with btn_start held high, assert reset for 1 cycle:
  - All outputs 0 on the following cycle.
  - Releasing reset with btn_start still high -> stays IDLE.
  - Release and re-press of btn_start -> RUN.
